// File: rtl/mc_pkg.sv
// Purpose : shared command codes, FSM state encodings and size defaults for memory_controller.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package mc_pkg;

    localparam int MC_DATA_W = 8;
    localparam int MC_ADDR_W = 6;

    typedef enum logic [2:0] {
        CMD_IDLE  = 3'b000,
        CMD_PROC  = 3'b001,
        CMD_TRANS = 3'b010,
        CMD_STORE = 3'b100
    } mc_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_STORE   = 3'd1,
        ST_RD_ADDR = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_DONE    = 3'd4,
        ST_HOLD    = 3'd5
    } mc_state_e;

    // Any code outside the four legal commands behaves exactly like idle.
    function automatic mc_cmd_e decode_cmd(input logic [2:0] raw);
        mc_cmd_e cmd;
        case (raw)
            3'b100:  cmd = CMD_STORE;
            3'b010:  cmd = CMD_TRANS;
            3'b001:  cmd = CMD_PROC;
            default: cmd = CMD_IDLE;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/mc_mem.sv
// Purpose : 2^ADDR_W x DATA_W single-port RAM, synchronous write, registered synchronous read.
// Latency : read data valid one cycle after re_i; write lands on the same edge.
// Backpressure: none; the owner never issues a read and a write together.
// Ports   : clk_i clock; we_i/re_i strobes; addr_i shared address; wdata_i write word;
//           rdata_o read word (holds its value while re_i is low).
module mc_mem
    import mc_pkg::*;
#(
    parameter int DATA_W = MC_DATA_W,
    parameter int ADDR_W = MC_ADDR_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_controller.sv
// Purpose : job-based controller: stores a block of words, then hands them out one per transfer command.
// Latency : store takes one word per cycle, mc_done one cycle after the last word; transfer
//           pulses mc_done two cycles after the 010 command is sampled.
// Backpressure: mc_data_in_ready is high only in STORE while words of the job remain.
// Ports   : mc_clk/mc_reset_n clock and async active-low reset; ctrl_data_contition command;
//           mc_data_length job size; mc_data_in/_valid/_ready input stream; procc_done from the
//           processing unit; mc_done/mc_data_done status; mc_reg_out/mc_reg_valid outgoing word.
module memory_controller
    import mc_pkg::*;
#(
    parameter int DATA_W = MC_DATA_W,
    parameter int ADDR_W = MC_ADDR_W
) (
    input  logic              mc_clk,
    input  logic              mc_reset_n,
    input  logic [2:0]        ctrl_data_contition,
    input  logic [ADDR_W-1:0] mc_data_length,
    input  logic [DATA_W-1:0] mc_data_in,
    input  logic              mc_data_in_valid,
    output logic              mc_data_in_ready,
    input  logic              procc_done,
    output logic              mc_done,
    output logic              mc_data_done,
    output logic [DATA_W-1:0] mc_reg_out,
    output logic              mc_reg_valid
);

    // Pointers and length carry one extra bit so a full job never wraps a compare.
    mc_state_e         state_q, state_d;
    mc_cmd_e           start_cmd_q, start_cmd_d;
    mc_cmd_e           cmd;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] reg_out_q, reg_out_d;
    logic              reg_valid_q, reg_valid_d;

    logic              mem_we, mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    mc_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i   (mc_clk),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (mem_addr),
        .wdata_i (mc_data_in),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        cmd              = decode_cmd(ctrl_data_contition);
        state_d          = state_q;
        start_cmd_d      = start_cmd_q;
        len_d            = len_q;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        reg_out_d        = reg_out_q;
        reg_valid_d      = reg_valid_q;
        mem_we           = 1'b0;
        mem_re           = 1'b0;
        mem_addr         = rd_ptr_q[ADDR_W-1:0];
        mc_data_in_ready = 1'b0;
        mc_done          = 1'b0;

        if (cmd == CMD_IDLE) begin
            // Idle aborts whatever is running; job length and pointers survive.
            state_d     = ST_IDLE;
            reg_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd == CMD_STORE) begin
                        len_d       = {1'b0, mc_data_length};
                        wr_ptr_d    = '0;
                        rd_ptr_d    = '0;
                        reg_valid_d = 1'b0;
                        start_cmd_d = cmd;
                        state_d     = ST_STORE;
                    end else if (cmd == CMD_TRANS) begin
                        start_cmd_d = cmd;
                        if (rd_ptr_q < len_q) begin
                            mem_re  = 1'b1;
                            state_d = ST_RD_ADDR;
                        end else begin
                            reg_valid_d = 1'b0;
                            state_d     = ST_DONE;
                        end
                    end
                end
                ST_STORE: begin
                    mem_addr         = wr_ptr_q[ADDR_W-1:0];
                    mc_data_in_ready = (wr_ptr_q < len_q);
                    if (mc_data_in_valid && mc_data_in_ready) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                    // Leaves on the edge of the last write, or at once for an empty job.
                    if (wr_ptr_d == len_q) begin
                        state_d = ST_DONE;
                    end
                end
                ST_RD_ADDR: begin
                    state_d = ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    reg_out_d   = mem_rdata;
                    reg_valid_d = 1'b1;
                    rd_ptr_d    = rd_ptr_q + 1'b1;
                    state_d     = ST_DONE;
                end
                ST_DONE: begin
                    mc_done = 1'b1;
                    state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    // A held command must change before another operation may start.
                    if (cmd != start_cmd_q) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge mc_clk or negedge mc_reset_n) begin
        if (!mc_reset_n) begin
            state_q     <= ST_IDLE;
            start_cmd_q <= CMD_IDLE;
            len_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            reg_out_q   <= '0;
            reg_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_cmd_q <= start_cmd_d;
            len_q       <= len_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            reg_out_q   <= reg_out_d;
            reg_valid_q <= reg_valid_d;
        end
    end

    // Gated by reset so the flag stays low while reset is held.
    assign mc_data_done = mc_reset_n && (cmd == CMD_PROC) && (rd_ptr_q == len_q)
                          && (procc_done || (len_q == '0));
    assign mc_reg_out   = reg_out_q;
    assign mc_reg_valid = reg_valid_q;

endmodule

// File: tb/tb_memory_controller.sv
// Purpose : self-checking bench for memory_controller against a job-level reference model.
// Latency : n/a.
// Backpressure: n/a.
module tb_memory_controller;

    logic       mc_clk;
    logic       mc_reset_n;
    logic [2:0] cmd;
    logic [5:0] len;
    logic [7:0] din;
    logic       vld;
    logic       rdy;
    logic       pd;
    logic       done;
    logic       ddone;
    logic [7:0] reg_out;
    logic       reg_vld;

    memory_controller #(.DATA_W(8), .ADDR_W(6)) dut (
        .mc_clk              (mc_clk),
        .mc_reset_n          (mc_reset_n),
        .ctrl_data_contition (cmd),
        .mc_data_length      (len),
        .mc_data_in          (din),
        .mc_data_in_valid    (vld),
        .mc_data_in_ready    (rdy),
        .procc_done          (pd),
        .mc_done             (done),
        .mc_data_done        (ddone),
        .mc_reg_out          (reg_out),
        .mc_reg_valid        (reg_vld)
    );

    initial begin
        mc_clk = 1'b0;
        forever #5 mc_clk = ~mc_clk;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: memory image, job length, words handed out, current output word.
    logic [7:0] mem_m [64];
    int         len_m = 0;
    int         rd_m  = 0;
    logic [7:0] reg_m = 8'h00;
    logic       vld_m = 1'b0;
    logic [7:0] dirq [$];

    typedef struct {
        int         ctx;
        logic [2:0] c;
        logic       p;
        logic       exp_dd;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge mc_clk);
        @(negedge mc_clk);
    endtask

    function automatic logic exp_ddone(input logic p);
        return (rd_m == len_m) && (p || (len_m == 0));
    endfunction

    // abort_mode: 0 none, 1 idle command, 2 reset pulse; triggered once abort_at words are in.
    task automatic store_job(input int n, input int vmode, input int abort_mode, input int abort_at);
        int  wr = 0;
        int  acc = 0;
        bit  finished = 0;
        cmd = 3'b100; len = 6'(n); vld = 1'b0; pd = 1'b0;
        step();
        len_m = n; rd_m = 0; vld_m = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (abort_mode == 1 && wr == abort_at) begin
                cmd = 3'b000; vld = 1'b0;
                step();
                #1;
                chk("abort_ready", 32'(rdy), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                chk("abort_valid", 32'(reg_vld), 32'd0);
                return;
            end
            if (abort_mode == 2 && wr == abort_at) begin
                mc_reset_n = 1'b0; cmd = 3'b001; pd = 1'b1; vld = 1'b0;
                #1;
                chk("rst_ready", 32'(rdy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_ddone", 32'(ddone), 32'd0);
                chk("rst_reg_out", 32'(reg_out), 32'd0);
                chk("rst_valid", 32'(reg_vld), 32'd0);
                step();
                mc_reset_n = 1'b1; cmd = 3'b000; pd = 1'b0;
                len_m = 0; rd_m = 0; reg_m = 8'h00; vld_m = 1'b0;
                step();
                return;
            end
            case (vmode)
                0:       vld = 1'b1;
                1:       vld = ((c % 2) == 0);
                default: vld = 1'($urandom_range(0, 1));
            endcase
            din = (dirq.size() > 0) ? dirq[0] : 8'($urandom);
            #1;
            chk("store_ready", 32'(rdy), 32'(wr < n));
            chk("store_done", 32'(done), 32'd0);
            chk("store_valid", 32'(reg_vld), 32'd0);
            if (rdy && vld) acc++;
            if (vld && wr < n) begin
                mem_m[wr] = din;
                wr++;
                if (dirq.size() > 0) void'(dirq.pop_front());
            end
            finished = (wr == n);
            step();
            if (finished) break;
        end
        vld = 1'b0;
        chk("store_finished", 32'(finished), 32'd1);
        chk("store_accepts", 32'(acc), 32'(n));
        #1;
        chk("store_done_pulse", 32'(done), 32'd1);
        chk("store_ready_off", 32'(rdy), 32'd0);
        step();
        #1;
        chk("store_done_once", 32'(done), 32'd0);
        cmd = 3'b001; pd = 1'($urandom_range(0, 1));
        #1;
        chk("store_ddone", 32'(ddone), 32'(exp_ddone(pd)));
        step();
        pd = 1'b0;
    endtask

    task automatic read_pass(input int hold_cycles);
        int exp_lat;
        int lat = 0;
        bit got = 0;
        cmd = 3'b010; pd = 1'b0;
        exp_lat = (rd_m < len_m) ? 3 : 1;
        for (int c = 1; c <= 8; c++) begin
            step();
            #1;
            if (done) begin
                got = 1; lat = c;
                break;
            end
        end
        chk("rd_done_seen", 32'(got), 32'd1);
        chk("rd_latency", 32'(lat), 32'(exp_lat));
        if (rd_m < len_m) begin
            reg_m = mem_m[rd_m]; vld_m = 1'b1; rd_m++;
        end else begin
            vld_m = 1'b0;
        end
        chk("rd_valid", 32'(reg_vld), 32'(vld_m));
        chk("rd_reg_out", 32'(reg_out), 32'(reg_m));
        for (int h = 0; h < hold_cycles; h++) begin
            step();
            #1;
            chk("hold_no_done", 32'(done), 32'd0);
            chk("hold_reg_out", 32'(reg_out), 32'(reg_m));
            chk("hold_valid", 32'(reg_vld), 32'(vld_m));
        end
        cmd = 3'b001; pd = 1'b0;
        #1;
        chk("proc_ddone_nopd", 32'(ddone), 32'(exp_ddone(1'b0)));
        step();
        pd = 1'b1;
        #1;
        chk("proc_ddone_pd", 32'(ddone), 32'(exp_ddone(1'b1)));
        step();
        pd = 1'b0;
    endtask

    task automatic apply_table(input int ctx);
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].ctx == ctx) begin
                cmd = tbl[i].c; pd = tbl[i].p;
                #1;
                chk("tbl_ddone", 32'(ddone), 32'(tbl[i].exp_dd));
                chk("tbl_done", 32'(done), 32'd0);
                cmd = 3'b001; pd = 1'b0;
                step();
            end
        end
    endtask

    initial begin
        // ctx 0: just after reset (length 0); ctx 1: four-word job fully handed out.
        tbl[0]  = '{0, 3'b001, 1'b0, 1'b1};
        tbl[1]  = '{0, 3'b001, 1'b1, 1'b1};
        tbl[2]  = '{0, 3'b000, 1'b1, 1'b0};
        tbl[3]  = '{0, 3'b011, 1'b1, 1'b0};
        tbl[4]  = '{0, 3'b101, 1'b0, 1'b0};
        tbl[5]  = '{0, 3'b111, 1'b1, 1'b0};
        tbl[6]  = '{0, 3'b110, 1'b1, 1'b0};
        tbl[7]  = '{1, 3'b001, 1'b0, 1'b0};
        tbl[8]  = '{1, 3'b001, 1'b1, 1'b1};
        tbl[9]  = '{1, 3'b011, 1'b1, 1'b0};
        tbl[10] = '{1, 3'b000, 1'b1, 1'b0};
        tbl[11] = '{1, 3'b101, 1'b1, 1'b0};

        mc_reset_n = 1'b0; cmd = 3'b001; pd = 1'b1; len = 6'd0; din = 8'h00; vld = 1'b0;
        @(negedge mc_clk);
        #1;
        chk("reset_ready", 32'(rdy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_ddone", 32'(ddone), 32'd0);
        chk("reset_reg_out", 32'(reg_out), 32'd0);
        chk("reset_valid", 32'(reg_vld), 32'd0);
        step();
        mc_reset_n = 1'b1; cmd = 3'b000; pd = 1'b0;
        step();

        apply_table(0);

        // Four-word job, then four transfer/process passes.
        dirq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        store_job(4, 0, 0, 0);
        read_pass(10);
        chk("word0_A1", 32'(reg_out), 32'hA1);
        read_pass(1);
        chk("word1_B2", 32'(reg_out), 32'hB2);
        read_pass(1);
        chk("word2_C3", 32'(reg_out), 32'hC3);
        read_pass(1);
        chk("word3_D4", 32'(reg_out), 32'hD4);
        apply_table(1);

        // Illegal codes behave as idle: nothing starts, the output word goes invalid.
        cmd = 3'b111;
        for (int i = 0; i < 3; i++) begin
            step();
            vld_m = 1'b0;
            #1;
            chk("bad_cmd_done", 32'(done), 32'd0);
            chk("bad_cmd_ready", 32'(rdy), 32'd0);
            chk("bad_cmd_valid", 32'(reg_vld), 32'd0);
        end
        cmd = 3'b001;
        step();

        // Reset after two of five words, then a fresh three-word job.
        store_job(5, 0, 2, 2);
        store_job(3, 0, 0, 0);
        for (int i = 0; i < 4; i++) read_pass(1);

        // Empty job.
        store_job(0, 0, 0, 0);
        read_pass(1);

        // Longest job with valid toggling.
        store_job(63, 1, 0, 0);
        for (int i = 0; i < 63; i++) read_pass(0);

        // Idle command in the middle of a store.
        store_job(5, 0, 1, 2);
        for (int i = 0; i < 2; i++) read_pass(0);

        // Randomised jobs.
        for (int j = 0; j < 20; j++) begin
            int n;
            int reads;
            n = $urandom_range(0, 10);
            reads = $urandom_range(0, n + 1);
            store_job(n, 2, 0, 0);
            for (int r = 0; r < reads; r++) read_pass(0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/memory_controller.md
MEMORY_CONTROLLER -- requirements
Module: memory_controller

Interface
REQ-001 Parameter DATA_W, default 8, data word width.
REQ-002 Parameter ADDR_W, default 6, address width; depth = 2^ADDR_W = 64 words.
REQ-003 One clock, mc_clk; reset is asynchronous and active-low, mc_reset_n.
REQ-004 mc_clk  in  1  rising-edge clock.
REQ-005 mc_reset_n  in  1  asynchronous active-low reset.
REQ-006 ctrl_data_contition  in  3  core-control command: 100 store, 010 transfer, 001 processing, 000 idle.
REQ-007 mc_data_length  in  ADDR_W  number of words in the job.
REQ-008 mc_data_in  in  DATA_W  input data word.
REQ-009 mc_data_in_valid  in  1  input word valid.
REQ-010 mc_data_in_ready  out  1  controller accepts input word this cycle.
REQ-011 procc_done  in  1  processing unit finished the current word.
REQ-012 mc_done  out  1  one-cycle pulse: store or transfer operation complete.
REQ-013 mc_data_done  out  1  all stored words transferred and processed.
REQ-014 mc_reg_out  out  DATA_W  word handed to the processing unit.
REQ-015 mc_reg_valid  out  1  mc_reg_out holds a valid word.

Function
REQ-016 FSM states are IDLE, STORE, RD_ADDR, RD_DATA, DONE, HOLD.
REQ-017 IDLE with command 100: latch mc_data_length into len_q, clear wr_ptr and rd_ptr, clear mc_reg_valid, go to STORE.
REQ-018 STORE: mc_data_in_ready = 1 while wr_ptr < len_q; a word is written to mem[wr_ptr] and wr_ptr increments on each cycle with valid && ready.
REQ-019 STORE exits to DONE on the edge after the last accepted write, or on the next edge if len_q = 0.
REQ-020 IDLE with command 010 and rd_ptr < len_q: go to RD_ADDR and issue a synchronous read of mem[rd_ptr].
REQ-021 RD_ADDR goes to RD_DATA; RD_DATA loads mc_reg_out from memory, sets mc_reg_valid, increments rd_ptr, and goes to DONE.
REQ-022 IDLE with command 010 and rd_ptr = len_q: go directly to DONE without a read; mc_reg_valid is cleared.
REQ-023 DONE: mc_done = 1 for exactly one cycle, then go to HOLD.
REQ-024 HOLD: stay until the command differs from the command that started the operation, then return to IDLE; this guarantees one operation per command.
REQ-025 mc_data_done = 1 (combinational) when command = 001, rd_ptr = len_q, and either procc_done = 1 or len_q = 0.
REQ-026 Command 000 in any state: return to IDLE on the next edge, clear mc_reg_valid, deassert ready; len_q and the pointers are kept until the next 100.
REQ-027 Command 001 or 000 seen in IDLE starts no memory operation.
REQ-028 Command 100 arriving mid-transfer (HOLD or IDLE) restarts a store job per REQ-017.
REQ-029 Invalid command codes (011, 101, 110, 111) are treated as 000.
REQ-030 Pointers are ADDR_W+1 bits wide, so a comparison against len_q never wraps; writes are never accepted beyond len_q.

Reset
REQ-031 mc_reset_n low asynchronously forces: state IDLE, wr_ptr/rd_ptr/len_q = 0, mc_done = 0, mc_reg_out = 0, mc_reg_valid = 0, mc_data_in_ready = 0, mc_data_done = 0.
REQ-032 Memory contents are not reset.
REQ-033 Reset asserted mid-operation abandons the job; after release the block is in IDLE and ready for a new command.

Structure
REQ-034 The shared package mc_pkg holds the command codes (CMD_IDLE, CMD_STORE, CMD_TRANS, CMD_PROC), the FSM state encodings, and the DATA_W/ADDR_W defaults.
REQ-035 Sub-module mc_mem: 2^ADDR_W x DATA_W single-port RAM with synchronous write and registered synchronous read.

Verification
REQ-036 Reset, then command 100 with length 4 and words A1,B2,C3,D4 streamed with valid held high -> ready high for 4 cycles, one mc_done pulse one cycle after D4.
REQ-037 After REQ-036, four passes of 010 -> 001 with procc_done -> mc_reg_out = A1,B2,C3,D4 in order, each with mc_done 2 cycles after 010 is sampled; mc_data_done asserts only in the fourth 001 phase with procc_done.
REQ-038 Length 0 store -> no ready, mc_done on the next cycle; a following 010 -> mc_done with mc_reg_valid = 0; 001 -> mc_data_done = 1 immediately.
REQ-039 Length 63 store with valid toggling every other cycle -> exactly 63 writes, ready drops after the 63rd, readback matches.
REQ-040 mc_reset_n pulsed low mid-store (after 2 of 5 words) -> all outputs at reset values at once; a new 100 job with length 3 completes correctly.
REQ-041 Command held at 010 for 10 cycles after mc_done -> no second read and no second pulse; command 000 mid-STORE -> IDLE with ready = 0 on the next cycle.
